// File: rtl/rv32i_rtype_epu_dispatch.sv
// rv32i_rtype_epu_dispatch
// Custom R-type instruction front end for an array of NUM_CH bias-add epilogue
// cores. Claimed instructions (opcode 0x33, funct7 F7_ID) dispatch X/Bias
// writes, START (with op mode), C reads, status reads and error clears.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   instr_valid/ready, instr      CPU custom-instruction handshake and word
//   rs1_val, rs2_val, rd_addr     operands and destination register
//   rd_we, rd_waddr, rd_wdata     one-cycle writeback
//   core_start, core_mode         per-channel start pulse, latched op mode
//   core_busy/done/C_valid        per-channel status
//   x_*, b_*                      X and Bias write ports (one-hot strobes)
//   c_rd_*                        C read request / response per channel
//   err_any                       OR of sticky timeout / illegal flags
module rv32i_rtype_epu_dispatch #(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned M       = 8,
   parameter int unsigned N       = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned BYTE_W  = DATA_W / 8,
   parameter int unsigned ROW_W   = (M > 1) ? $clog2(M) : 1,
   parameter int unsigned COL_W   = (N > 1) ? $clog2(N) : 1,
   parameter int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter logic [6:0]  F7_ID   = 7'h04,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     instr_valid,
   output logic                     instr_ready,
   input  logic [31:0]              instr,
   input  logic [31:0]              rs1_val,
   input  logic [31:0]              rs2_val,
   input  logic [4:0]               rd_addr,
   output logic                     rd_we,
   output logic [4:0]               rd_waddr,
   output logic [31:0]              rd_wdata,
   output logic [NUM_CH-1:0]        core_start,
   output logic [1:0]               core_mode,
   input  logic [NUM_CH-1:0]        core_busy,
   input  logic [NUM_CH-1:0]        core_done,
   input  logic [NUM_CH-1:0]        core_C_valid,
   output logic [NUM_CH-1:0]        x_we,
   output logic [NUM_CH-1:0]        b_we,
   output logic [ROW_W-1:0]         x_row,
   output logic [COL_W-1:0]         x_col,
   output logic [COL_W-1:0]         b_col,
   output logic [DATA_W-1:0]        x_wdata,
   output logic [DATA_W-1:0]        b_wdata,
   output logic [BYTE_W-1:0]        x_wmask,
   output logic [BYTE_W-1:0]        b_wmask,
   output logic [NUM_CH-1:0]        c_rd_en,
   output logic [ROW_W-1:0]         c_rd_row,
   output logic [COL_W-1:0]         c_rd_col,
   input  logic [NUM_CH*DATA_W-1:0] c_rd_rdata,
   input  logic [NUM_CH-1:0]        c_rd_rvalid,
   output logic                     err_any
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);

   typedef enum logic [0:0] {StIdle, StWaitC} state_t;

   state_t              state_q;
   logic [CH_W-1:0]     rd_ch_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                err_timeout_q, err_illegal_q;

   logic [2:0]          funct3;
   logic                fire, ch_ok, illegal_set, timeout_set, clr_hit;
   logic [CH_W-1:0]     ch;
   logic [NUM_CH-1:0]   ch_onehot, start_acc;
   logic [31:0]         stat_word;
   logic [DATA_W-1:0]   rdata_sel;
   logic                rvalid_sel;
   logic                unused_bits;

   assign funct3      = instr[14:12];
   assign instr_ready = (state_q == StIdle);
   assign fire        = instr_valid && instr_ready && (instr[6:0] == 7'h33) &&
                        (instr[31:25] == F7_ID);
   // Range check uses the full 3-bit channel field so out-of-range values are
   // not aliased onto a real channel by truncation.
   assign ch_ok       = 32'(rs1_val[18:16]) < NUM_CH;
   assign ch          = rs1_val[16 +: CH_W];
   assign ch_onehot   = NUM_CH'(1) << ch;
   assign start_acc   = (rs2_val[1:0] == 2'd3) ? '0 : (rs1_val[NUM_CH-1:0] & ~core_busy);
   assign x_wmask     = '1;
   assign b_wmask     = '1;
   assign err_any     = err_timeout_q | err_illegal_q;
   assign unused_bits = ^{instr, rs1_val};

   always_comb begin
      stat_word                 = '0;
      stat_word[NUM_CH-1:0]     = core_busy;
      stat_word[8 +: NUM_CH]    = core_done;
      stat_word[16 +: NUM_CH]   = core_C_valid;
      stat_word[24]             = err_timeout_q;
      stat_word[25]             = err_illegal_q;
   end

   // Response mux for the channel latched at CRD; other channels are ignored.
   always_comb begin
      rdata_sel  = '0;
      rvalid_sel = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (rd_ch_q == CH_W'(k)) begin
            rdata_sel  = c_rd_rdata[k*DATA_W +: DATA_W];
            rvalid_sel = c_rd_rvalid[k];
         end
      end
   end

   always_comb begin
      illegal_set = 1'b0;
      if (fire) begin
         case (funct3)
            3'b000, 3'b001, 3'b011: illegal_set = !ch_ok;
            3'b010:                 illegal_set = (rs2_val[1:0] == 2'd3);
            3'b110, 3'b111:         illegal_set = 1'b1;
            default:                illegal_set = 1'b0;
         endcase
      end
   end

   assign timeout_set = (state_q == StWaitC) && !rvalid_sel && (cnt_q == CNT_W'(TIMEOUT - 1));
   assign clr_hit     = fire && (funct3 == 3'b101);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         rd_ch_q       <= '0;
         cnt_q         <= '0;
         err_timeout_q <= 1'b0;
         err_illegal_q <= 1'b0;
         rd_we         <= 1'b0;
         rd_waddr      <= '0;
         rd_wdata      <= '0;
         core_start    <= '0;
         core_mode     <= '0;
         x_we          <= '0;
         b_we          <= '0;
         x_row         <= '0;
         x_col         <= '0;
         b_col         <= '0;
         x_wdata       <= '0;
         b_wdata       <= '0;
         c_rd_en       <= '0;
         c_rd_row      <= '0;
         c_rd_col      <= '0;
      end else begin
         x_we       <= '0;
         b_we       <= '0;
         core_start <= '0;
         rd_we      <= 1'b0;
         // Set takes priority over a simultaneous clear.
         err_timeout_q <= timeout_set | (err_timeout_q & ~clr_hit);
         err_illegal_q <= illegal_set | (err_illegal_q & ~clr_hit);
         unique case (state_q)
            StIdle: begin
               if (fire) begin
                  rd_waddr <= rd_addr;
                  case (funct3)
                     3'b000: begin
                        if (ch_ok) begin
                           x_we    <= ch_onehot;
                           x_row   <= rs1_val[ROW_W-1:0];
                           x_col   <= rs1_val[ROW_W +: COL_W];
                           x_wdata <= rs2_val;
                        end else begin
                           rd_we    <= 1'b1;
                           rd_wdata <= '0;
                        end
                     end
                     3'b001: begin
                        if (ch_ok) begin
                           b_we    <= ch_onehot;
                           b_col   <= rs1_val[COL_W-1:0];
                           b_wdata <= rs2_val;
                        end else begin
                           rd_we    <= 1'b1;
                           rd_wdata <= '0;
                        end
                     end
                     3'b010: begin
                        core_start <= start_acc;
                        core_mode  <= rs2_val[1:0];
                        rd_we      <= 1'b1;
                        rd_wdata   <= 32'(start_acc);
                     end
                     3'b011: begin
                        if (ch_ok) begin
                           state_q  <= StWaitC;
                           rd_ch_q  <= ch;
                           cnt_q    <= '0;
                           c_rd_en  <= ch_onehot;
                           c_rd_row <= rs1_val[ROW_W-1:0];
                           c_rd_col <= rs1_val[ROW_W +: COL_W];
                        end else begin
                           rd_we    <= 1'b1;
                           rd_wdata <= '0;
                        end
                     end
                     3'b100: begin
                        rd_we    <= 1'b1;
                        rd_wdata <= stat_word;
                     end
                     default: begin
                        rd_we    <= 1'b1;
                        rd_wdata <= '0;
                     end
                  endcase
               end
            end
            StWaitC: begin
               if (rvalid_sel) begin
                  rd_we    <= 1'b1;
                  rd_wdata <= rdata_sel;
                  c_rd_en  <= '0;
                  state_q  <= StIdle;
               end else if (timeout_set) begin
                  rd_we    <= 1'b1;
                  rd_wdata <= 32'hDEAD_BEEF;
                  c_rd_en  <= '0;
                  state_q  <= StIdle;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rv32i_rtype_epu_dispatch.sv
module tb_rv32i_rtype_epu_dispatch;

   localparam int NCH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr = '0, rs1_val = '0, rs2_val = '0;
   logic [4:0]  rd_addr = '0;
   logic        rd_we;
   logic [4:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic [NCH-1:0] core_start, core_busy = '0, core_done = '0, core_C_valid = '0;
   logic [1:0]  core_mode;
   logic [NCH-1:0] x_we, b_we, c_rd_en, c_rd_rvalid = '0;
   logic [2:0]  x_row, c_rd_row;
   logic [2:0]  x_col, b_col, c_rd_col;
   logic [31:0] x_wdata, b_wdata;
   logic [3:0]  x_wmask, b_wmask;
   logic [NCH*32-1:0] c_rd_rdata = '0;
   logic        err_any;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } rd_exp_t;

   rd_exp_t q[$];
   rd_exp_t mon_e;
   int vectors = 0;
   int miscompares = 0;

   rv32i_rtype_epu_dispatch #(.NUM_CH(NCH), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
      .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
      .core_start(core_start), .core_mode(core_mode), .core_busy(core_busy),
      .core_done(core_done), .core_C_valid(core_C_valid),
      .x_we(x_we), .b_we(b_we), .x_row(x_row), .x_col(x_col), .b_col(b_col),
      .x_wdata(x_wdata), .b_wdata(b_wdata), .x_wmask(x_wmask), .b_wmask(b_wmask),
      .c_rd_en(c_rd_en), .c_rd_row(c_rd_row), .c_rd_col(c_rd_col),
      .c_rd_rdata(c_rd_rdata), .c_rd_rvalid(c_rd_rvalid), .err_any(err_any)
   );

   always #5 clk = ~clk;

   // Scoreboard: every writeback must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && rd_we === 1'b1) begin
         vectors++;
         if (q.size() == 0) begin
            miscompares++;
            $display("FAIL rd_unexpected: got waddr=%0d wdata=%h, required no writeback",
                     rd_waddr, rd_wdata);
         end else begin
            mon_e = q.pop_front();
            if ({rd_waddr, rd_wdata} !== mon_e) begin
               miscompares++;
               $display("FAIL rd_write: got waddr=%0d wdata=%h, required waddr=%0d wdata=%h",
                        rd_waddr, rd_wdata, mon_e.a, mon_e.d);
            end
         end
      end
   end

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [6:0] op);
      return {f7, 10'd0, f3, 5'd0, op};
   endfunction

   function automatic logic [31:0] stat_exp(input logic to, input logic ill);
      return {6'd0, ill, to, 4'd0, core_C_valid, 4'd0, core_done, 4'd0, core_busy};
   endfunction

   // Presents one instruction; returns at posedge+1 of the cycle after acceptance.
   task automatic send(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [4:0] rd);
      int n = 0;
      while (instr_ready !== 1'b1 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 50) begin
         vectors++; miscompares++;
         $display("FAIL send_ready: instr_ready=%b after %0d cycles, required 1", instr_ready, n);
      end
      instr = w; rs1_val = r1; rs2_val = r2; rd_addr = rd; instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      vectors++;
      if ({instr_ready, rd_we, x_we, b_we, core_start, c_rd_en, core_mode, err_any} !==
          {1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_ctrl: got rdy=%b we=%b x=%b b=%b st=%b en=%b md=%0d err=%b, required 1 0 0 0 0 0 0 0",
                  instr_ready, rd_we, x_we, b_we, core_start, c_rd_en, core_mode, err_any);
      end
      vectors++;
      if ({x_wmask, b_wmask, rd_wdata, x_wdata, x_row, x_col} !== {8'hFF, 64'd0, 6'd0}) begin
         miscompares++;
         $display("FAIL reset_data: got mask=%h/%h rdw=%h xw=%h row=%0d col=%0d, required ff 0",
                  x_wmask, b_wmask, rd_wdata, x_wdata, x_row, x_col);
      end
   endtask

   task automatic test_xwr();
      send(mk(7'h04, 3'b000, 7'h33), 32'h0001_0013, 32'h3F80_0000, 5'd5);
      vectors++;
      if ({x_we, x_row, x_col, x_wdata, b_we, rd_we} !== {4'b0010, 3'd3, 3'd2, 32'h3F80_0000, 4'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL xwr: got we=%b row=%0d col=%0d d=%h bwe=%b rdwe=%b, required 0010 3 2 3f800000 0 0",
                  x_we, x_row, x_col, x_wdata, b_we, rd_we);
      end
      @(posedge clk); #1;
      vectors++;
      if (x_we !== 4'b0) begin
         miscompares++;
         $display("FAIL xwr_pulse: got x_we=%b, required 0000", x_we);
      end
   endtask

   task automatic test_bwr();
      send(mk(7'h04, 3'b001, 7'h33), 32'h0003_0005, 32'hC0A0_0000, 5'd6);
      vectors++;
      if ({b_we, b_col, b_wdata, x_we} !== {4'b1000, 3'd5, 32'hC0A0_0000, 4'b0}) begin
         miscompares++;
         $display("FAIL bwr: got we=%b col=%0d d=%h xwe=%b, required 1000 5 c0a00000 0",
                  b_we, b_col, b_wdata, x_we);
      end
   endtask

   task automatic test_start();
      core_busy = 4'b0100;
      q.push_back('{a: 5'd7, d: 32'h0000_000B});
      send(mk(7'h04, 3'b010, 7'h33), 32'h0000_000F, 32'd1, 5'd7);
      core_busy = 4'b0000;
      vectors++;
      if ({core_start, core_mode} !== {4'b1011, 2'd1}) begin
         miscompares++;
         $display("FAIL start: got start=%b mode=%0d, required 1011 1", core_start, core_mode);
      end
      @(posedge clk); #1;
      vectors++;
      if ({core_start, core_mode} !== {4'b0000, 2'd1}) begin
         miscompares++;
         $display("FAIL start_hold: got start=%b mode=%0d, required 0000 1", core_start, core_mode);
      end
   endtask

   task automatic test_crd();
      c_rd_rdata = {32'h1111_1111, 32'h4000_0000, 32'h2222_2222, 32'h3333_3333};
      c_rd_rvalid = 4'b0001; // foreign channel, must be ignored
      q.push_back('{a: 5'd9, d: 32'h4000_0000});
      send(mk(7'h04, 3'b011, 7'h33), 32'h0002_0016, 32'd0, 5'd9);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({c_rd_en, instr_ready, c_rd_row, c_rd_col} !== {4'b0100, 1'b0, 3'd6, 3'd2}) begin
            miscompares++;
            $display("FAIL crd_wait%0d: got en=%b rdy=%b row=%0d col=%0d, required 0100 0 6 2",
                     i, c_rd_en, instr_ready, c_rd_row, c_rd_col);
         end
         if (i == 2) c_rd_rvalid = 4'b0101;
         else @(posedge clk);
         if (i != 2) #1;
      end
      @(posedge clk); #1;
      c_rd_rvalid = 4'b0000;
      vectors++;
      if ({rd_we, c_rd_en, instr_ready} !== {1'b1, 4'b0000, 1'b1}) begin
         miscompares++;
         $display("FAIL crd_done: got rdwe=%b en=%b rdy=%b, required 1 0000 1", rd_we, c_rd_en, instr_ready);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      core_busy = 4'b0011; core_done = 4'b0101; core_C_valid = 4'b1000;
      q.push_back('{a: 5'd3, d: 32'hDEAD_BEEF});
      send(mk(7'h04, 3'b011, 7'h33), 32'h0001_0000, 32'd0, 5'd3);
      while (rd_we !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      vectors++;
      if (n != 8) begin
         miscompares++;
         $display("FAIL timeout_cycles: got %0d wait cycles, required 8", n);
      end
      vectors++;
      if (err_any !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_err: got err_any=%b, required 1", err_any);
      end
      q.push_back('{a: 5'd4, d: stat_exp(1'b1, 1'b0)});
      send(mk(7'h04, 3'b100, 7'h33), 32'd0, 32'd0, 5'd4);
      q.push_back('{a: 5'd4, d: 32'd0});
      send(mk(7'h04, 3'b101, 7'h33), 32'd0, 32'd0, 5'd4);
      vectors++;
      if (err_any !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_err: got err_any=%b, required 0", err_any);
      end
      q.push_back('{a: 5'd4, d: stat_exp(1'b0, 1'b0)});
      send(mk(7'h04, 3'b100, 7'h33), 32'd0, 32'd0, 5'd4);
      core_busy = '0; core_done = '0; core_C_valid = '0;
   endtask

   task automatic test_illegal();
      q.push_back('{a: 5'd10, d: 32'd0});
      send(mk(7'h04, 3'b111, 7'h33), 32'h0000_000F, 32'd0, 5'd10);
      vectors++;
      if ({core_start, x_we, b_we, c_rd_en, err_any} !== {16'd0, 1'b1}) begin
         miscompares++;
         $display("FAIL illegal_f3: got st=%b x=%b b=%b en=%b err=%b, required 0 0 0 0 1",
                  core_start, x_we, b_we, c_rd_en, err_any);
      end
      q.push_back('{a: 5'd11, d: 32'd0});
      send(mk(7'h04, 3'b000, 7'h33), 32'h0005_0000, 32'h1234_5678, 5'd11);
      vectors++;
      if (x_we !== 4'b0) begin
         miscompares++;
         $display("FAIL illegal_ch_xwr: got x_we=%b, required 0000", x_we);
      end
      q.push_back('{a: 5'd12, d: 32'd0});
      send(mk(7'h04, 3'b011, 7'h33), 32'h0006_0000, 32'd0, 5'd12);
      vectors++;
      if ({c_rd_en, instr_ready} !== {4'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL illegal_ch_crd: got en=%b rdy=%b, required 0000 1", c_rd_en, instr_ready);
      end
      q.push_back('{a: 5'd13, d: 32'd0});
      send(mk(7'h04, 3'b010, 7'h33), 32'h0000_000F, 32'd3, 5'd13);
      vectors++;
      if (core_start !== 4'b0) begin
         miscompares++;
         $display("FAIL illegal_mode3: got start=%b, required 0000", core_start);
      end
      q.push_back('{a: 5'd14, d: stat_exp(1'b0, 1'b1)});
      send(mk(7'h04, 3'b100, 7'h33), 32'd0, 32'd0, 5'd14);
      q.push_back('{a: 5'd14, d: 32'd0});
      send(mk(7'h04, 3'b101, 7'h33), 32'd0, 32'd0, 5'd14);
   endtask

   task automatic test_unclaimed();
      send(mk(7'h05, 3'b000, 7'h33), 32'h0001_0000, 32'hFFFF_FFFF, 5'd1);
      send(mk(7'h04, 3'b100, 7'h13), 32'd0, 32'd0, 5'd1);
      vectors++;
      if ({x_we, err_any, x_wdata} !== {4'b0, 1'b0, 32'h3F80_0000}) begin
         miscompares++;
         $display("FAIL unclaimed: got x_we=%b err=%b xd=%h, required 0000 0 3f800000",
                  x_we, err_any, x_wdata);
      end
   endtask

   task automatic test_back_to_back();
      q.push_back('{a: 5'd20, d: 32'h0000_0003});
      send(mk(7'h04, 3'b010, 7'h33), 32'h0000_0003, 32'd2, 5'd20);
      send(mk(7'h04, 3'b000, 7'h33), 32'h0003_003F, 32'hAAAA_5555, 5'd21);
      vectors++;
      if ({x_we, x_row, x_col, x_wdata, core_start, core_mode} !==
          {4'b1000, 3'd7, 3'd7, 32'hAAAA_5555, 4'b0, 2'd2}) begin
         miscompares++;
         $display("FAIL b2b: got x=%b row=%0d col=%0d d=%h st=%b md=%0d, required 1000 7 7 aaaa5555 0 2",
                  x_we, x_row, x_col, x_wdata, core_start, core_mode);
      end
   endtask

   task automatic test_reset_wait();
      send(mk(7'h04, 3'b011, 7'h33), 32'h0000_0009, 32'd0, 5'd2);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      vectors++;
      if ({rd_we, instr_ready, c_rd_en, core_mode, x_row, x_wdata, c_rd_row} !==
          {1'b0, 1'b1, 4'b0, 2'd0, 3'd0, 32'd0, 3'd0}) begin
         miscompares++;
         $display("FAIL reset_wait: got we=%b rdy=%b en=%b md=%0d row=%0d xd=%h crow=%0d, required 0 1 0 0 0 0 0",
                  rd_we, instr_ready, c_rd_en, core_mode, x_row, x_wdata, c_rd_row);
      end
      repeat (10) @(posedge clk);
      #1;
   endtask

   initial begin
      test_reset();
      test_xwr();
      test_bwr();
      test_start();
      test_crd();
      test_timeout();
      test_illegal();
      test_unclaimed();
      test_back_to_back();
      repeat (2) @(posedge clk);
      #1;
      test_reset_wait();
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL rd_missing: got %0d outstanding writebacks, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rv32i_rtype_epu_dispatch.md
Name: rv32i_rtype_epu_dispatch

Overview:
Multi-channel successor to the single-core R-type bias-add instruction front end. It decodes custom R-type instructions from the CPU and dispatches X/Bias writes, START (with op mode), and C reads to one of NUM_CH external epilogue cores. It adds a per-channel START mask with a busy check, a C-read timeout, sticky error flags, and an error-clear instruction. It sits between the CPU custom-instruction port and an array of bias-add cores.

Parameters:
NUM_CH, 4, number of cores; 1..8.
M, 8, rows per core.
N, 8, columns per core.
DATA_W, 32, data width; fixed at 32 (fp32 bits).
BYTE_W, DATA_W/8, write-mask width.
ROW_W, max(1,clog2(M)), row index width.
COL_W, max(1,clog2(N)), column index width; ROW_W+COL_W must be ≤16.
CH_W, max(1,clog2(NUM_CH)), channel index width.
F7_ID, 7'h04, funct7 claimed by this block.
TIMEOUT, 64, maximum cycles a CRD waits for rvalid; ≥2.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_valid  in  1  CPU offers instruction
instr_ready  out  1  block can accept
instr  in  32  instruction word
rs1_val  in  32  rs1 operand
rs2_val  in  32  rs2 operand
rd_addr  in  5  destination register
rd_we  out  1  one-cycle writeback strobe
rd_waddr  out  5  writeback register
rd_wdata  out  32  writeback data
core_start  out  NUM_CH  per-channel start pulse
core_mode  out  2  op mode latched at START: 0 = bias add, 1 = bias add + ReLU, 2 = pass X, 3 = reserved
core_busy / core_done / core_C_valid  in  NUM_CH each  per-channel status
x_we, b_we  out  NUM_CH each  one-hot write pulses
x_row  out  ROW_W; x_col / b_col  out  COL_W; x_wdata / b_wdata  out  DATA_W; x_wmask / b_wmask  out  BYTE_W, always all ones
c_rd_en  out  NUM_CH  read request, one-hot
c_rd_row  out  ROW_W; c_rd_col  out  COL_W
c_rd_rdata  in  NUM_CH*DATA_W  channel k occupies bits [k*32 +: 32]
c_rd_rvalid  in  NUM_CH  per-channel read valid
err_any  out  1  OR of the sticky error flags

Behaviour:
- Decode: instruction is claimed when opcode=0x33 and funct7=F7_ID. Fields: row=rs1[ROW_W-1:0], col=rs1[ROW_W+:COL_W], ch=rs1[16+:CH_W]. Handshake fires when instr_valid && instr_ready. Unclaimed instructions are ignored with no side effects.
- instr_ready=1 only in S_IDLE.
- funct3=000 XWR: next cycle x_we[ch]=1 for 1 cycle, with row/col and x_wdata=rs2. No rd write.
- funct3=001 BWR: col=rs1[COL_W-1:0], ch=rs1[16+:CH_W]. Next cycle b_we[ch]=1 for 1 cycle, b_wdata=rs2. No rd write.
- funct3=010 START: req=rs1[NUM_CH-1:0], acc=req & ~core_busy, both sampled at acceptance. Next cycle: core_start=acc for 1 cycle, core_mode=rs2[1:0] (held until the next START), rd_we=1, rd_wdata=zero-extended acc. Mode 3 sets err_illegal and gives acc=0.
- funct3=011 CRD: latch ch/row/col/rd, go to S_WAIT_C, clear the timeout counter. In S_WAIT_C, c_rd_en[ch]=1 with addr held from the first WAIT cycle. When c_rd_rvalid[ch]=1, the next cycle gives rd_we=1, rd_wdata=channel-ch rdata, and a return to S_IDLE. When the counter reaches TIMEOUT-1 with no rvalid, the next cycle gives rd_we=1, rd_wdata=32'hDEAD_BEEF, err_timeout=1, and a return to S_IDLE. rvalid from other channels is ignored.
- funct3=100 STAT: next cycle rd_we=1, rd_wdata = busy in [7:0], done in [15:8], C_valid in [23:16], err_timeout in [24], err_illegal in [25], zero elsewhere. Unused channel bits are zero.
- funct3=101 CLR: clear both sticky errors. rd_we with rd_wdata=0.
- funct3=110/111, or any ch≥NUM_CH on XWR/BWR/CRD: set err_illegal, no core strobe. The next cycle gives rd_we=1, rd_wdata=0, and no WAIT.
- Error flags stay set until CLR or rst. If a CLR and a new error occur in the same cycle, set wins.
- All strobes (x_we, b_we, core_start, rd_we) last exactly 1 cycle. The block issues at most one rd_we per accepted instruction.
- Reset values: all strobes 0, c_rd_en 0, all data/address outputs 0, masks all ones, core_mode 0, errors 0, state S_IDLE. Reset during S_WAIT_C aborts the read with no rd_we.

Test Plan:
- XWR with rs1=0x0001_0013 (ch1, row3, col2), rs2=0x3F80_0000 -> x_we=4'b0010 for one cycle, x_row=3, x_col=2, x_wdata=0x3F800000. No rd_we.
- START with rs1=0xF, rs2=1 while core_busy=4'b0100 -> core_start=4'b1011, core_mode=1, rd_wdata=0xB.
- CRD on ch2, with rvalid[2] asserted 3 cycles after entering WAIT and rdata=0x4000_0000 -> c_rd_en=4'b0100 held for 3 cycles, rd_we with 0x40000000, instr_ready low throughout WAIT.
- CRD with no rvalid (TIMEOUT=8) -> rd_wdata=0xDEADBEEF after 8 WAIT cycles. A following STAT reads bit24=1 and err_any=1. CLR clears it and STAT bit24 then reads 0.
- funct3=111, and XWR with ch=5 when NUM_CH=4 -> no core strobe, rd_wdata=0, STAT bit25=1.
- Assert rst two cycles into WAIT -> no rd_we, instr_ready=1 the cycle after reset, all outputs at reset values.
